// File: rtl/t_ff_arb_pkg.sv
// rtl/t_ff_arb_pkg.sv - shared types, defaults and round-robin helper for the toggle arbiter
package t_ff_arb_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index that follows idx in round-robin order over n requesters
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - synchronous T flip-flop shared by all requesters
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  // Toggle on every enabled edge; clear on active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/t_ff_toggle_arbiter.sv
// rtl/t_ff_toggle_arbiter.sv - round-robin burst arbiter for one shared T-FF; TOGGLE_STATS_EN adds toggle_total
module t_ff_toggle_arbiter
  import t_ff_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*CW-1:0]      cnt_in,
  input  logic                 hold,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 done,
  output logic                 q
`ifdef TOGGLE_STATS_EN
  ,
  output logic [15:0]          toggle_total
`endif
);

  localparam int IW = $clog2(N);

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   remaining;
  logic [CW-1:0]   cnt_arr [N];
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  int              j;
  logic            t;

  // Unpack the flat count bus into one field per requester
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_arr[i] = cnt_in[i*CW +: CW];
    end
  end

  // First set request at or after the pointer; scanning backwards lets the nearest one win
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    j          = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      cand = IW'(j);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next state and the toggle enable driven into the shared cell
  always_comb begin
    state_n = state;
    t       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = (cnt_arr[pick_idx] == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        t = ~hold;
        if (t && remaining == CW'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; reset aborts any burst without a done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Grant pulse, owner id, pointer advance and burst countdown
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt       <= '0;
      gnt_id    <= '0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      gnt <= '0;
      if (state == IDLE && pick_valid) begin
        gnt[pick_idx] <= 1'b1;
        gnt_id        <= pick_idx;
        remaining     <= cnt_arr[pick_idx];
        ptr           <= IW'(rr_next(int'(pick_idx), N));
      end else if (t && remaining != '0) begin
        remaining <= remaining - CW'(1);
      end
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

  t_ff_cell u_cell (
    .clk (clk),
    .rst (rst),
    .t   (t),
    .q   (q)
  );

`ifdef TOGGLE_STATS_EN
  // Running count of every toggle applied to the cell; wraps naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      toggle_total <= '0;
    end else if (t) begin
      toggle_total <= toggle_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_t_ff_toggle_arbiter.sv
// tb/tb_t_ff_toggle_arbiter.sv - scoreboard bench for the T-FF toggle arbiter
module tb_t_ff_toggle_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  typedef struct {
    int   id;
    int   cnt;
    logic qend;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] cnt_in = '0;
  logic            hold = 1'b0;
  logic [N-1:0]    gnt;
  logic [1:0]      gnt_id;
  logic            busy;
  logic            done;
  logic            q;
`ifdef TOGGLE_STATS_EN
  logic [15:0]     toggle_total;
`endif

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  int   m_ptr = 0;
  logic m_q = 1'b0;
  int   m_toggles = 0;
  bit   mon_en = 1'b0;
  bit   mon_busy = 1'b0;
  bit   hold_en = 1'b0;

  t_ff_toggle_arbiter #(.N(N), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .cnt_in       (cnt_in),
    .hold         (hold),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .done         (done),
    .q            (q)
`ifdef TOGGLE_STATS_EN
    ,
    .toggle_total (toggle_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      hold = hold_en && ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : monitor
    exp_t e;
    int   n;
    int   h;
    int   tg;
    int   to;
    logic qp;
    forever begin
      @(negedge clk);
      if (mon_en && gnt != '0) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_gnt", gnt, 0);
        end else begin
          e = sb.pop_front();
          check("gnt_onehot", gnt, 32'(1) << e.id);
          check("gnt_id", gnt_id, e.id);
          n = 0; h = 0; tg = 0; to = 0; qp = q;
          while (!done && to < 300) begin
            if (hold) h++;
            n++;
            @(negedge clk);
            if (q !== qp) tg++;
            qp = q;
            to++;
          end
          check("done_seen", done, 1);
          check("burst_cycles", n, e.cnt + h);
          check("toggle_count", tg, e.cnt);
          check("q_end", q, e.qend);
          @(negedge clk);
          check("done_one_cycle", done, 0);
          check("busy_after", busy, 0);
          check("gap_no_gnt", gnt, 0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic run_round(input logic [N-1:0] mask, input logic [N*CW-1:0] cv);
    int   last;
    int   to;
    exp_t e;
    @(posedge clk);
    #1;
    cnt_in = cv;
    last = m_ptr;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (mask[idx]) begin
        e.id = idx;
        e.cnt = int'(cv[idx*CW +: CW]);
        m_q = m_q ^ e.cnt[0];
        e.qend = m_q;
        m_toggles += e.cnt;
        sb.push_back(e);
        last = idx;
      end
    end
    m_ptr = (last + 1) % N;
    req = mask;
    to = 0;
    while (req != '0 && to < 400) begin
      @(negedge clk);
      req = req & ~gnt;
      to++;
    end
    check("all_granted", req, 0);
    req = '0;
  endtask

  task automatic drain();
    int to;
    to = 0;
    while ((sb.size() != 0 || mon_busy || busy) && to < 500) begin
      @(negedge clk);
      to++;
    end
    @(negedge clk);
    @(negedge clk);
    check("drained", sb.size(), 0);
  endtask

  initial begin : stim
    logic [N*CW-1:0] cv;
    logic [N-1:0]    mask;
    int              to;
    int              tg;
    int              dn;
    logic            qp;

    rst = 1'b0;
    req = '1;
    cnt_in = {N{4'd3}};
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_gnt_id", gnt_id, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", q, 0);
`ifdef TOGGLE_STATS_EN
      check("rst_stats", toggle_total, 0);
`endif
    end
    @(posedge clk);
    #1;
    req = '0;
    rst = 1'b1;
    mon_en = 1'b1;

    run_round(4'b0010, {4'd0, 4'd0, 4'd3, 4'd0});
    run_round(4'b1111, {N{4'd1}});
    run_round(4'b1111, {N{4'd1}});
    hold_en = 1'b1;
    run_round(4'b0100, {4'd0, 4'd4, 4'd0, 4'd0});
    run_round(4'b0001, {4'd7, 4'd7, 4'd7, 4'd0});
    run_round(4'b1000, {N{4'd15}});
    for (int r = 0; r < 14; r++) begin
      mask = N'($urandom_range(1, 15));
      cv = (N*CW)'($urandom);
      run_round(mask, cv);
    end
    drain();
`ifdef TOGGLE_STATS_EN
    check("stats_total", toggle_total, m_toggles & 32'hFFFF);
`endif

    mon_en = 1'b0;
    hold_en = 1'b0;
    @(posedge clk);
    #1;
    cnt_in = {4'd0, 4'd0, 4'd0, 4'd5};
    req = 4'b0001;
    to = 0;
    dn = 0;
    while (gnt == '0 && to < 50) begin
      @(negedge clk);
      to++;
    end
    check("abort_gnt", gnt, 1);
    req = '0;
    tg = 0;
    qp = q;
    to = 0;
    while (tg < 2 && to < 50) begin
      @(negedge clk);
      if (done) dn++;
      if (q !== qp) tg++;
      qp = q;
      to++;
    end
    check("abort_two_toggles", tg, 2);
    rst = 1'b0;
    @(negedge clk);
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    check("abort_gnt_id", gnt_id, 0);
`ifdef TOGGLE_STATS_EN
    check("abort_stats", toggle_total, 0);
`endif
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);

    m_ptr = 0;
    m_q = 1'b0;
    m_toggles = 0;
    mon_en = 1'b1;
    run_round(4'b0001, {4'd0, 4'd0, 4'd0, 4'd3});
    run_round(4'b0010, {4'd0, 4'd0, 4'd4, 4'd0});
    drain();
    check("final_q", q, m_q);
`ifdef TOGGLE_STATS_EN
    check("stats_after_reset", toggle_total, m_toggles);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
